ram_arbiter: RTL and testbench

Single-port RAM arbiter that shares the 2 KiB system RAM between the 6502 core and the VGA renderer's screen fetch port. The screen port has priority; the CPU is stalled through its RDY input whenever it loses the port. A bounded-burst guard prevents CPU starvation. The arbiter realigns the RAM's one-cycle read latency so each requester sees only its own data, and sits between `cpu`/`vga_render` and `generic_ram` in the top level.

---
 rtl/easy6502_pkg.sv | 13 +
 rtl/sat_counter.sv | 25 ++
 rtl/ram_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/easy6502_pkg.sv
// rtl/easy6502_pkg.sv - shared constants for the easy6502 system
//
// Grant encoding used by the RAM arbiter and the default geometry of the
// 2 KiB system RAM.
package easy6502_pkg;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_SCR = 1'b1;

  localparam int RAM_ADDR_W = 11;
  localparam int RAM_DATA_W = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// Counts cycles with inc high and sticks at all-ones.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears count)
//   inc        : count enable
//   count      : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between the 6502 core and screen fetch
//
// The screen fetch port has priority; the CPU is stalled through cpu_rdy when
// it loses the port. After MAX_BURST consecutive screen grants one CPU slot is
// forced (MAX_BURST=0 disables the guard). Read data returns one cycle after
// the grant; the CPU keeps seeing the data of its last granted access while
// stalled.
//
// Optional feature macro: RAM_ARB_STATS_EN adds the stall_count port.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   cpu_addr/wdata/we       : CPU bus (held by the core while cpu_rdy=0)
//   cpu_rdata, cpu_rdy      : CPU read data and ready/stall
//   scr_req, scr_addr       : screen read request
//   scr_ready               : screen request accepted this cycle
//   scr_rdata, scr_rvalid   : screen read data and its valid strobe
//   ram_addr/wdata/we       : single RAM port
//   ram_rdata               : RAM read data (one cycle latency)
//   stall_count             : cycles with cpu_rdy=0, saturating (RAM_ARB_STATS_EN)
module ram_arbiter
  import easy6502_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdy,
  input  logic              scr_req,
  input  logic [ADDR_W-1:0] scr_addr,
  output logic              scr_ready,
  output logic [DATA_W-1:0] scr_rdata,
  output logic              scr_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  // MAX_BURST=0 would give a zero-width counter; keep one bit that stays 0.
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

  logic              grant;
  logic              last_grant;
  logic [BW-1:0]     burst_cnt;
  logic [DATA_W-1:0] hold_q;
  logic              burst_ok;

  // Per-cycle grant: screen wins unless the burst guard forces a CPU slot.
  always_comb begin
    burst_ok = (MAX_BURST == 0) || (burst_cnt < BURST_LIM);
    grant    = (scr_req && !reset && burst_ok) ? GNT_SCR : GNT_CPU;
  end

  // Port mux. Write data is always the CPU's; it is ignored on screen grants
  // because ram_we is held low.
  always_comb begin
    ram_wdata = cpu_wdata;
    if (grant == GNT_SCR) begin
      ram_addr = scr_addr;
      ram_we   = 1'b0;
    end else begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we && !reset;
    end
  end

  assign cpu_rdy   = (grant == GNT_CPU);
  assign scr_ready = (grant == GNT_SCR);

  // Return path: the RAM output belongs to whoever was granted last cycle.
  assign scr_rvalid = (last_grant == GNT_SCR);
  assign scr_rdata  = ram_rdata;
  // While stalled the CPU sees the last data it was given, never screen data.
  assign cpu_rdata  = reset ? '0 : ((last_grant == GNT_CPU) ? ram_rdata : hold_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GNT_CPU;
      hold_q     <= '0;
      burst_cnt  <= '0;
    end else begin
      last_grant <= grant;
      if (last_grant == GNT_CPU) begin
        hold_q <= ram_rdata;
      end
      if (grant == GNT_CPU) begin
        burst_cnt <= '0;
      end else if (MAX_BURST != 0) begin
        // A screen grant implies burst_cnt < MAX_BURST, so this cannot overshoot.
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

`ifdef RAM_ARB_STATS_EN
  sat_counter #(
    .W(16)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (!cpu_rdy),
    .count(stall_count)
  );
`else
  // Statistics disabled: no stall counter is built.
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rdy;
  logic          scr_req;
  logic [AW-1:0] scr_addr;
  logic          scr_ready;
  logic [DW-1:0] scr_rdata;
  logic          scr_rvalid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   stall_count;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_BURST(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .cpu_rdy    (cpu_rdy),
    .scr_req    (scr_req),
    .scr_addr   (scr_addr),
    .scr_ready  (scr_ready),
    .scr_rdata  (scr_rdata),
    .scr_rvalid (scr_rvalid),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
`ifdef RAM_ARB_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  // Behavioural single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  initial begin
    logic exp_scr;
    logic prev_scr;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[11'h3FF] = 8'hC3;
    mem[11'h010] = 8'h11;
    mem[11'h030] = 8'h77;

    reset     = 1'b1;
    cpu_addr  = 11'h100;
    cpu_wdata = 8'hFF;
    cpu_we    = 1'b1;          // must be blocked by reset
    scr_req   = 1'b1;          // must be ignored during reset
    scr_addr  = 11'h3FF;

    // ---- reset state ----
    next_cycle();
    next_cycle();
    settle();
    check_val("rst_cpu_rdy",    cpu_rdy,    1);
    check_val("rst_scr_ready",  scr_ready,  0);
    check_val("rst_scr_rvalid", scr_rvalid, 0);
    check_val("rst_ram_we",     ram_we,     0);
    check_val("rst_cpu_rdata",  cpu_rdata,  0);
`ifdef RAM_ARB_STATS_EN
    check_val("rst_stall_count", stall_count, 0);
`endif

    // ---- CPU only: write 0x5A to 0x200 then read it back ----
    next_cycle();
    reset = 1'b0; scr_req = 1'b0;
    cpu_addr = 11'h200; cpu_wdata = 8'h5A; cpu_we = 1'b1;
    settle();
    check_val("cpu_wr_rdy",  cpu_rdy,  1);
    check_val("cpu_wr_we",   ram_we,   1);
    check_val("cpu_wr_addr", ram_addr, 32'h200);
    next_cycle();
    cpu_we = 1'b0;
    settle();
    check_val("cpu_rd_rdy", cpu_rdy, 1);
    // ---- next cycle: read data returns; screen read starts (cycle t) ----
    next_cycle();
    scr_req = 1'b1; scr_addr = 11'h3FF; cpu_addr = 11'h010;
    settle();
    check_val("cpu_rd_data",   cpu_rdata, 8'h5A);
    check_val("cpu_wr_mem",    mem[11'h200], 8'h5A);
    check_val("scr_t_cpu_rdy", cpu_rdy,   0);
    check_val("scr_t_ready",   scr_ready, 1);
    check_val("scr_t_addr",    ram_addr,  32'h3FF);
    next_cycle();              // t+1
    scr_req = 1'b0;
    settle();
    check_val("scr_t1_rvalid", scr_rvalid, 1);
    check_val("scr_t1_rdata",  scr_rdata,  8'hC3);
    check_val("scr_t1_cpu_rdy", cpu_rdy,   1);
    check_val("scr_t1_cpu_hold", cpu_rdata, 8'h5A);
    next_cycle();              // t+2
    settle();
    check_val("scr_t2_cpu_rdata", cpu_rdata,  8'h11);
    check_val("scr_t2_rvalid",    scr_rvalid, 0);

    // ---- stalled write ----
    next_cycle();
    scr_req = 1'b1; scr_addr = 11'h3FF;
    cpu_addr = 11'h020; cpu_wdata = 8'hEE; cpu_we = 1'b1;
    settle();
    check_val("stw_ram_we",  ram_we,  0);
    check_val("stw_cpu_rdy", cpu_rdy, 0);
    next_cycle();
    scr_req = 1'b0;
    settle();
    check_val("stw_rvalid",  scr_rvalid, 1);
    check_val("stw_rdata",   scr_rdata,  8'hC3);
    check_val("stw_we_late", ram_we,     1);
    check_val("stw_addr",    ram_addr,   32'h020);
    next_cycle();
    cpu_we = 1'b0; cpu_addr = 11'h030;   // hold-path read of 0x77 starts here
    settle();
    check_val("stw_mem",     mem[11'h020], 8'hEE);
    check_val("stw_mem_scr", mem[11'h3FF], 8'hC3);

    // ---- hold path ----
    next_cycle();
    scr_req = 1'b1; scr_addr = 11'h3FF;
    settle();
    check_val("hold_first", cpu_rdata, 8'h77);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 2) scr_req = 1'b0;
      settle();
      check_val($sformatf("hold_%0d", i), cpu_rdata, 8'h77);
    end

    // ---- reset to zero stats, then burst guard ----
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; scr_req = 1'b1;
    prev_scr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) next_cycle();
      settle();
      exp_scr = ((i % 5) != 4);
      check_val($sformatf("burst_ready_%0d", i),  scr_ready,  exp_scr);
      check_val($sformatf("burst_rdy_%0d", i),    cpu_rdy,    !exp_scr);
      check_val($sformatf("burst_rvalid_%0d", i), scr_rvalid, prev_scr);
      prev_scr = exp_scr;
    end
    next_cycle();              // cycle 20: SCR again
    settle();
    check_val("burst_wrap_ready", scr_ready, 1);
`ifdef RAM_ARB_STATS_EN
    check_val("burst_stall_count", stall_count, 16);
`endif

    // ---- reset mid-burst ----
    next_cycle();              // cycle 21: SCR
    next_cycle();
    reset = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h040; cpu_wdata = 8'hAB;
    settle();
    check_val("rmb_scr_ready", scr_ready, 0);
    check_val("rmb_cpu_rdy",   cpu_rdy,   1);
    check_val("rmb_ram_we",    ram_we,    0);
    next_cycle();
    settle();
    check_val("rmb_rvalid",    scr_rvalid, 0);
    check_val("rmb_cpu_rdy2",  cpu_rdy,    1);
    check_val("rmb_ram_we2",   ram_we,     0);
    next_cycle();
    reset = 1'b0; cpu_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) next_cycle();
      settle();
      check_val($sformatf("rel_ready_%0d", i), scr_ready, (i != 4));
      if (i == 0) check_val("rel_rvalid", scr_rvalid, 0);
    end
    check_val("rmb_mem_untouched", mem[11'h040], 8'h00);
`ifdef RAM_ARB_STATS_EN
    check_val("rel_stall_count", stall_count, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
